psum_writeback: RTL

Drain engine that sits directly downstream of the corelet's output FIFO. It pops the column-wide partial-sum words produced by the MAC array, applies an optional per-lane ReLU, and writes them to consecutive addresses of the PSUM SRAM. The ReLU is needed in output-stationary mode, where corelet results bypass the SFP. It replaces testbench-driven `inst[6]` sequencing with a start/done handshake that the top-level controller can drive.

---
 rtl/psum_writeback_if.sv | 31 +++
 rtl/psum_writeback.sv | 123 ++++++++++++
 2 files changed

// File: rtl/psum_writeback_if.sv
// Control, OFIFO-drain and PSUM-SRAM signals of the partial-sum writeback engine.
// The master side is the controller/corelet environment; the slave side is the engine.
interface psum_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
);
  logic                     start;
  logic [addr_bw-1:0]       base_addr;
  logic [addr_bw-1:0]       num_words;
  logic                     relu_en;
  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     pmem_cen;
  logic                     pmem_wen;
  logic [addr_bw-1:0]       pmem_addr;
  logic [col*psum_bw-1:0]   pmem_d;
  logic                     busy;
  logic                     done;

  modport master (
    output start, base_addr, num_words, relu_en, ofifo_valid, ofifo_out,
    input  ofifo_rd, pmem_cen, pmem_wen, pmem_addr, pmem_d, busy, done
  );

  modport slave (
    input  start, base_addr, num_words, relu_en, ofifo_valid, ofifo_out,
    output ofifo_rd, pmem_cen, pmem_wen, pmem_addr, pmem_d, busy, done
  );
endinterface

// File: rtl/psum_writeback.sv
// Drains num_words partial-sum words from the corelet OFIFO into consecutive PSUM SRAM
// addresses, with optional per-lane ReLU, under a start/busy/done handshake.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic              clk,
  input  logic              reset,
  psum_writeback_if.slave   bus
);
  localparam int word_bw = col * psum_bw;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;

  logic [addr_bw-1:0]   num_words_reg;
  logic [addr_bw-1:0]   cnt_reg;
  logic [addr_bw-1:0]   next_addr_reg;
  logic [addr_bw-1:0]   wr_addr_reg;
  logic                 relu_en_reg;
  logic                 valid_reg;
  logic [word_bw-1:0]   data_reg;
  logic [word_bw-1:0]   relu_word;

  logic                 accept;
  logic                 pop;
  logic                 last_pop;

  assign accept   = (state_reg == IDLE) && bus.start;
  assign pop      = (state_reg == DRAIN) && bus.ofifo_valid && (cnt_reg < num_words_reg);
  assign last_pop = pop && ((cnt_reg + addr_bw'(1)) == num_words_reg);

  // Lane-wise ReLU on the OFIFO head; negative lanes are zeroed, others pass untouched.
  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_relu
      logic [psum_bw-1:0] lane;
      assign lane = bus.ofifo_out[gi*psum_bw +: psum_bw];
      assign relu_word[gi*psum_bw +: psum_bw] =
        (relu_en_reg && lane[psum_bw-1]) ? '0 : lane;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A zero-length transfer still passes through FLUSH so that done lands two cycles
  // after start, the same tail latency as a transfer whose last pop was at cycle 0.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.num_words == '0) ? FLUSH : DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_next = FLUSH;
        end
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_words_reg <= '0;
      cnt_reg       <= '0;
      next_addr_reg <= '0;
      wr_addr_reg   <= '0;
      relu_en_reg   <= 1'b0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
    end else begin
      valid_reg <= pop;
      if (accept) begin
        num_words_reg <= bus.num_words;
        relu_en_reg   <= bus.relu_en;
        next_addr_reg <= bus.base_addr;
        cnt_reg       <= '0;
      end
      // Address and data registers only move on a pop, so they hold between writes.
      if (pop) begin
        data_reg      <= relu_word;
        wr_addr_reg   <= next_addr_reg;
        next_addr_reg <= next_addr_reg + addr_bw'(1);
        cnt_reg       <= cnt_reg + addr_bw'(1);
      end
    end
  end

  assign bus.ofifo_rd  = pop;
  assign bus.pmem_cen  = ~valid_reg;
  assign bus.pmem_wen  = ~valid_reg;
  assign bus.pmem_addr = wr_addr_reg;
  assign bus.pmem_d    = data_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);

`ifndef SYNTHESIS
  a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
    bus.ofifo_rd |-> bus.ofifo_valid);
  a_done_in_busy: assert property (@(posedge clk) disable iff (reset)
    bus.done |-> bus.busy);
`endif

endmodule
